// File: rtl/ram_pingpong_buf.sv
// Multi-bank ping-pong feature-map buffer: the producer fills one bank while the consumer drains another.
// Bank ownership moves through wr_done/rd_done; read latency is 1+RD_PIPE and is flagged by rd_valid.
module ram_pingpong_buf #(
    parameter int DW       = 8,
    parameter int ADDR_DW  = 5,
    parameter int RAM_SIZE = 32,
    parameter int NUM_BANK = 2,
    parameter int RD_PIPE  = 0,
    localparam int BW      = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_DW-1:0] wr_addr,
    input  logic [DW-1:0]      wr_data,
    input  logic               wr_done,
    output logic               wr_ready,
    output logic [BW-1:0]      wr_bank,
    input  logic               rd_en,
    input  logic [ADDR_DW-1:0] rd_addr,
    input  logic               rd_done,
    output logic               rd_ready,
    output logic [BW-1:0]      rd_bank,
    output logic [DW-1:0]      rd_data,
    output logic               rd_valid,
    output logic               err_wr,
    output logic               err_rd
);

    localparam int               DEPTH     = NUM_BANK * RAM_SIZE;
    localparam int               IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_DW:0] SIZE_W    = (ADDR_DW + 1)'(RAM_SIZE);
    localparam logic [BW-1:0]    LAST_BANK = BW'(NUM_BANK - 1);

    logic signed [DW-1:0] mem [DEPTH];

    logic [NUM_BANK-1:0]  full_q, full_d;
    logic [BW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [BW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 err_wr_q, err_wr_d;
    logic                 err_rd_q, err_rd_d;
    logic                 s1_valid_q, s1_valid_d;
    logic signed [DW-1:0] s1_data_q, s1_data_d;

    logic                 wr_ok, wr_done_ok, rd_ok, rd_done_ok;
    logic [IW-1:0]        wr_idx, rd_idx;

    function automatic logic [BW-1:0] next_ptr(input logic [BW-1:0] p);
        return (p == LAST_BANK) ? '0 : p + BW'(1);
    endfunction

    assign wr_ready = !full_q[wr_ptr_q];
    assign rd_ready = full_q[rd_ptr_q];
    assign wr_bank  = wr_ptr_q;
    assign rd_bank  = rd_ptr_q;
    assign err_wr   = err_wr_q;
    assign err_rd   = err_rd_q;

    assign wr_ok      = wr_en & wr_ready & ({1'b0, wr_addr} < SIZE_W);
    assign rd_ok      = rd_en & rd_ready & ({1'b0, rd_addr} < SIZE_W);
    assign wr_done_ok = wr_done & wr_ready;
    assign rd_done_ok = rd_done & rd_ready;

    // Both accesses use the pre-handoff pointers, so a strobe coinciding with done hits the old bank.
    assign wr_idx = IW'(wr_ptr_q) * IW'(RAM_SIZE) + IW'(wr_addr);
    assign rd_idx = IW'(rd_ptr_q) * IW'(RAM_SIZE) + IW'(rd_addr);

    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // A full bank is never the write bank, so the two updates touch different flags.
        if (wr_done_ok) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end
        if (rd_done_ok) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = next_ptr(rd_ptr_q);
        end
        err_wr_d   = err_wr_q | (wr_en & !wr_ok) | (wr_done & !wr_ready);
        err_rd_d   = err_rd_q | (rd_en & !rd_ok) | (rd_done & !rd_ready);
        s1_valid_d = rd_ok;
        s1_data_d  = rd_ok ? mem[rd_idx] : s1_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_wr_q   <= 1'b0;
            err_rd_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            full_q     <= full_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_wr_q   <= err_wr_d;
            err_rd_q   <= err_rd_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    if (RD_PIPE == 0) begin : g_no_pipe
        assign rd_data  = s1_data_q;
        assign rd_valid = s1_valid_q;
    end else begin : g_pipe
        logic                 s2_valid_q, s2_valid_d;
        logic signed [DW-1:0] s2_data_q, s2_data_d;

        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign rd_data  = s2_data_q;
        assign rd_valid = s2_valid_q;
    end

endmodule

// File: tb/tb_ram_pingpong_buf.sv
// Directed bench for ram_pingpong_buf: a default instance (RD_PIPE=0) and a piped,
// short-bank instance (RD_PIPE=1, RAM_SIZE=24) sharing stimulus with separate resets.
module tb_ram_pingpong_buf;

    logic       clk = 1'b0;
    logic       rst_n, rst_n1;
    logic       we, wdn, re, rdn;
    logic [4:0] wa, ra;
    logic [7:0] wd;

    logic       wrdy0, rrdy0, wb0, rb0, rv0, ew0, er0;
    logic [7:0] rd0;
    logic       wrdy1, rrdy1, wb1, rb1, rv1, ew1, er1;
    logic [7:0] rd1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ram_pingpong_buf #(.DW(8), .ADDR_DW(5), .RAM_SIZE(32), .NUM_BANK(2), .RD_PIPE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(we), .wr_addr(wa), .wr_data(wd), .wr_done(wdn),
        .wr_ready(wrdy0), .wr_bank(wb0),
        .rd_en(re), .rd_addr(ra), .rd_done(rdn),
        .rd_ready(rrdy0), .rd_bank(rb0), .rd_data(rd0), .rd_valid(rv0),
        .err_wr(ew0), .err_rd(er0)
    );

    ram_pingpong_buf #(.DW(8), .ADDR_DW(5), .RAM_SIZE(24), .NUM_BANK(2), .RD_PIPE(1)) dut1 (
        .clk(clk), .rst_n(rst_n1),
        .wr_en(we), .wr_addr(wa), .wr_data(wd), .wr_done(wdn),
        .wr_ready(wrdy1), .wr_bank(wb1),
        .rd_en(re), .rd_addr(ra), .rd_done(rdn),
        .rd_ready(rrdy1), .rd_bank(rb1), .rd_data(rd1), .rd_valid(rv1),
        .err_wr(ew1), .err_rd(er1)
    );

    typedef struct {
        logic       we;
        logic [4:0] wa;
        int         wd;
        logic       wdn;
        logic       re;
        logic [4:0] ra;
        logic       rdn;
        logic       x_wrdy;
        logic       x_rrdy;
        logic       x_wb;
        logic       x_rb;
        logic       x_rv;
        int         x_rd;
        logic       x_ew;
        logic       x_er;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(logic w_en, int w_a, int w_d, logic w_dn, logic r_en, int r_a,
                                logic r_dn, logic xwr, logic xrr, logic xwb, logic xrb,
                                logic xrv, int xrd, logic xew, logic xer);
        vec_t v;
        v.we = w_en; v.wa = 5'(w_a); v.wd = w_d; v.wdn = w_dn;
        v.re = r_en; v.ra = 5'(r_a); v.rdn = r_dn;
        v.x_wrdy = xwr; v.x_rrdy = xrr; v.x_wb = xwb; v.x_rb = xrb;
        v.x_rv = xrv; v.x_rd = xrd; v.x_ew = xew; v.x_er = xer;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else
            n_pass++;
    endtask

    // Drive one cycle of inputs, clock it, settle, then drop all strobes.
    task automatic cyc(input logic w_en, input int w_a, input int w_d, input logic w_dn,
                       input logic r_en, input int r_a, input logic r_dn);
        we = w_en; wa = 5'(w_a); wd = 8'(w_d); wdn = w_dn;
        re = r_en; ra = 5'(r_a); rdn = r_dn;
        @(posedge clk);
        #1;
        we = 1'b0; wdn = 1'b0; re = 1'b0; rdn = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rst_n1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; rst_n1 = 1'b1;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_wrdy"}, int'(wrdy0), 1);
        chk({tag, "_rrdy"}, int'(rrdy0), 0);
        chk({tag, "_wb"},   int'(wb0), 0);
        chk({tag, "_rb"},   int'(rb0), 0);
        chk({tag, "_rv"},   int'(rv0), 0);
        chk({tag, "_rd"},   int'(rd0), 0);
        chk({tag, "_ew"},   int'(ew0), 0);
        chk({tag, "_er"},   int'(er0), 0);
    endtask

    initial begin
        rst_n = 1'b0; rst_n1 = 1'b0;
        we = 1'b0; wdn = 1'b0; re = 1'b0; rdn = 1'b0;
        wa = '0; ra = '0; wd = '0;

        tbl[0]  = mk(1, 0,   1, 0, 0, 0, 0,  1, 1'b0, 0, 0, 0,  0, 0, 0);
        tbl[1]  = mk(1, 1,   4, 0, 0, 0, 0,  1, 1'b0, 0, 0, 0,  0, 0, 0);
        tbl[2]  = mk(1, 2,   7, 0, 0, 0, 0,  1, 1'b0, 0, 0, 0,  0, 0, 0);
        tbl[3]  = mk(1, 3,  10, 0, 0, 0, 0,  1, 1'b0, 0, 0, 0,  0, 0, 0);
        tbl[4]  = mk(0, 0,   0, 1, 0, 0, 0,  1, 1'b1, 1, 0, 0,  0, 0, 0);
        tbl[5]  = mk(1, 0,  -1, 0, 1, 0, 0,  1, 1'b1, 1, 0, 1,  1, 0, 0);
        tbl[6]  = mk(1, 1,  -2, 0, 1, 1, 0,  1, 1'b1, 1, 0, 1,  4, 0, 0);
        tbl[7]  = mk(1, 2,  -3, 0, 1, 2, 0,  1, 1'b1, 1, 0, 1,  7, 0, 0);
        tbl[8]  = mk(1, 3,  -4, 0, 1, 3, 0,  1, 1'b1, 1, 0, 1, 10, 0, 0);
        tbl[9]  = mk(0, 0,   0, 1, 1, 0, 1,  1, 1'b1, 0, 1, 1,  1, 0, 0);
        tbl[10] = mk(0, 0,   0, 0, 1, 2, 0,  1, 1'b1, 0, 1, 1, -3, 0, 0);
        tbl[11] = mk(0, 0,   0, 0, 0, 0, 0,  1, 1'b1, 0, 1, 0, -3, 0, 0);
        tbl[12] = mk(1, 31, 90, 1, 0, 0, 0,  0, 1'b1, 1, 1, 0, -3, 0, 0);
        tbl[13] = mk(0, 0,   0, 0, 0, 0, 1,  1, 1'b1, 1, 0, 0, -3, 0, 0);
        tbl[14] = mk(0, 0,   0, 0, 1, 31, 0, 1, 1'b1, 1, 0, 1, 90, 0, 0);
        tbl[15] = mk(0, 0,   0, 0, 0, 0, 1,  1, 1'b0, 1, 1, 0, 90, 0, 0);
        tbl[16] = mk(0, 0,   0, 0, 1, 4, 0,  1, 1'b0, 1, 1, 0, 90, 0, 1);
        tbl[17] = mk(0, 0,   0, 0, 0, 0, 1,  1, 1'b0, 1, 1, 0, 90, 0, 1);

        // Reset state, both during and after reset, and on the piped instance.
        repeat (2) @(posedge clk);
        #1;
        chk_reset0("rst_hold");
        chk("rst_hold_rv1", int'(rv1), 0);
        chk("rst_hold_rd1", int'(rd1), 0);
        @(negedge clk);
        rst_n = 1'b1; rst_n1 = 1'b1;
        idle();
        chk_reset0("rst_idle");

        // Fill bank 0 with addr-16, hand it over, read it back with no bubbles.
        for (int a = 0; a < 32; a++) cyc(1'b1, a, a - 16, 1'b0, 1'b0, 0, 1'b0);
        chk("fill_ew", int'(ew0), 0);
        chk("fill_rrdy_before_done", int'(rrdy0), 0);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
        chk("done_rrdy", int'(rrdy0), 1);
        chk("done_wb", int'(wb0), 1);
        chk("done_wrdy", int'(wrdy0), 1);
        chk("done_rb", int'(rb0), 0);
        for (int a = 0; a < 32; a++) begin
            cyc(1'b0, 0, 0, 1'b0, 1'b1, a, 1'b0);
            chk($sformatf("rd%0d_valid", a), int'(rv0), 1);
            chk($sformatf("rd%0d_data", a), int'($signed(rd0)), a - 16);
        end
        idle();
        chk("rd_idle_valid", int'(rv0), 0);
        chk("rd_idle_hold", int'($signed(rd0)), 15);

        // Both banks full: writes and wr_done are rejected.
        cyc(1'b1, 3, 7, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
        chk("full_wrdy", int'(wrdy0), 0);
        chk("full_wb", int'(wb0), 0);
        chk("full_ew_before", int'(ew0), 0);
        cyc(1'b1, 3, 99, 1'b0, 1'b0, 0, 1'b0);
        chk("full_wr_ew", int'(ew0), 1);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
        chk("full_done_wb", int'(wb0), 0);
        chk("full_done_wrdy", int'(wrdy0), 0);
        chk("full_done_rb", int'(rb0), 0);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 3, 1'b0);
        chk("full_mem_valid", int'(rv0), 1);
        chk("full_mem_unchanged", int'($signed(rd0)), -13);
        chk("full_er", int'(er0), 0);

        // Concurrent ping-pong, simultaneous handoffs, write+done at addr 31, rejected reads.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].we, int'(tbl[i].wa), tbl[i].wd, tbl[i].wdn,
                tbl[i].re, int'(tbl[i].ra), tbl[i].rdn);
            chk($sformatf("v%0d_wrdy", i), int'(wrdy0), int'(tbl[i].x_wrdy));
            chk($sformatf("v%0d_rrdy", i), int'(rrdy0), int'(tbl[i].x_rrdy));
            chk($sformatf("v%0d_wb", i),   int'(wb0),   int'(tbl[i].x_wb));
            chk($sformatf("v%0d_rb", i),   int'(rb0),   int'(tbl[i].x_rb));
            chk($sformatf("v%0d_rv", i),   int'(rv0),   int'(tbl[i].x_rv));
            chk($sformatf("v%0d_rd", i),   int'($signed(rd0)), tbl[i].x_rd);
            chk($sformatf("v%0d_ew", i),   int'(ew0),   int'(tbl[i].x_ew));
            chk($sformatf("v%0d_er", i),   int'(er0),   int'(tbl[i].x_er));
        end

        // RD_PIPE=1: two-cycle latency, then reset with a read in flight.
        do_reset();
        chk("p_rst_wrdy", int'(wrdy1), 1);
        chk("p_rst_rrdy", int'(rrdy1), 0);
        chk("p_rst_rv", int'(rv1), 0);
        cyc(1'b1, 5, -7, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
        chk("p_done_rrdy", int'(rrdy1), 1);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 5, 1'b0);
        chk("p_t1_rv", int'(rv1), 0);
        idle();
        chk("p_t2_rv", int'(rv1), 1);
        chk("p_t2_rd", int'($signed(rd1)), -7);
        idle();
        chk("p_t3_rv", int'(rv1), 0);
        chk("p_t3_hold", int'($signed(rd1)), -7);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 5, 1'b0);
        chk("p_mid_t1_rv", int'(rv1), 0);
        rst_n1 = 1'b0;
        #1;
        chk("p_async_rd", int'(rd1), 0);
        @(posedge clk);
        #1;
        chk("p_mid_t2_rv", int'(rv1), 0);
        chk("p_mid_t2_rd", int'(rd1), 0);
        @(negedge clk);
        rst_n1 = 1'b1;

        // Out-of-range addresses on the 24-word instance; memory survives reset.
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
        chk("b_rrdy", int'(rrdy1), 1);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 24, 1'b0);
        chk("b_oob_er", int'(er1), 1);
        idle();
        chk("b_oob_rv", int'(rv1), 0);
        chk("b_oob_rd", int'(rd1), 0);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 5, 1'b0);
        idle();
        chk("b_keep_rv", int'(rv1), 1);
        chk("b_keep_rd", int'($signed(rd1)), -7);
        chk("b_ew_before", int'(ew1), 0);
        cyc(1'b1, 24, 1, 1'b0, 1'b0, 0, 1'b0);
        chk("b_oob_ew", int'(ew1), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
